cardinal_nic: RTL and testbench

CARDINAL_NIC -- requirements
Module: cardinal_nic

---
 rtl/cardinal_pkg.sv | 13 +
 rtl/nic_channel_buffer.sv | 26 ++
 rtl/cardinal_nic.sv | 85 ++++++++
 tb/tb_cardinal_nic.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cardinal_pkg.sv
// Shared constants for the cardinal NIC: register map, data width, VC bit.
// Optional feature macro: CARDINAL_NIC_POLARITY_EN (see cardinal_nic).
package cardinal_pkg;

    localparam int DATA_W = 64;
    localparam int VC_BIT = 0;

    localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

endpackage

// File: rtl/nic_channel_buffer.sv
// One-entry packet buffer with a full flag; clear wins over load.
module nic_channel_buffer
    import cardinal_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [0:DATA_W-1] data_in,
    output logic [0:DATA_W-1] data,
    output logic              full
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= '0;
            full <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            data <= data_in;
            full <= 1'b1;
        end
    end

endmodule

// File: rtl/cardinal_nic.sv
// Cardinal router NIC: one-entry input/output channels, memory-mapped.
// Define CARDINAL_NIC_POLARITY_EN to gate injection on the packet VC bit.
module cardinal_nic
    import cardinal_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [0:1]        addr,
    input  logic [0:DATA_W-1] d_in,
    output logic [0:DATA_W-1] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [0:DATA_W-1] net_di,
    output logic              net_so,
    input  logic              net_ro,
    output logic [0:DATA_W-1] net_do,
    input  logic              net_polarity
);

    logic              rd;
    logic              wr;
    logic              in_full;
    logic              out_full;
    logic              in_load;
    logic              in_clear;
    logic              out_load;
    logic              out_clear;
    logic [0:DATA_W-1] in_data;
    logic [0:DATA_W-1] out_data;

    assign rd = nicEn & ~nicWrEn;
    assign wr = nicEn & nicWrEn;

    // Load is only possible while empty, clear only while full.
    assign in_load   = net_si & ~in_full;
    assign in_clear  = rd & (addr == ADDR_IN_BUF) & in_full;
    assign out_load  = wr & (addr == ADDR_OUT_BUF) & ~out_full;
    assign out_clear = net_so & net_ro;

    nic_channel_buffer u_in_buf (
        .clk     (clk),
        .reset   (reset),
        .load    (in_load),
        .clear   (in_clear),
        .data_in (net_di),
        .data    (in_data),
        .full    (in_full)
    );

    nic_channel_buffer u_out_buf (
        .clk     (clk),
        .reset   (reset),
        .load    (out_load),
        .clear   (out_clear),
        .data_in (d_in),
        .data    (out_data),
        .full    (out_full)
    );

    assign net_ri = ~in_full;
    assign net_do = out_data;

`ifdef CARDINAL_NIC_POLARITY_EN
    assign net_so = out_full & (out_data[VC_BIT] == net_polarity);
`else
    logic unused_polarity;
    assign unused_polarity = net_polarity;
    assign net_so = out_full;
`endif

    always_comb begin
        d_out = '0;
        if (rd) begin
            case (addr)
                ADDR_IN_BUF:   d_out = in_data;
                ADDR_IN_STAT:  d_out = {{(DATA_W-1){1'b0}}, in_full};
                ADDR_OUT_STAT: d_out = {{(DATA_W-1){1'b0}}, out_full};
                default:       d_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cardinal_nic.sv
// Self-checking bench for cardinal_nic: reference model plus directed vectors.
module tb_cardinal_nic;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [0:1]  addr = 2'b00;
    logic [0:63] d_in = '0;
    logic [0:63] d_out;
    logic        nicEn = 1'b0;
    logic        nicWrEn = 1'b0;
    logic        net_si = 1'b0;
    logic        net_ri;
    logic [0:63] net_di = '0;
    logic        net_so;
    logic        net_ro = 1'b0;
    logic [0:63] net_do;
    logic        net_polarity = 1'b0;

    int passed = 0;
    int total = 0;

    cardinal_nic dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    always #5 clk = ~clk;

    // Reference model: two mailboxes, each either empty or holding a word.
    bit          m_in_full = 0;
    bit          m_out_full = 0;
    logic [0:63] m_in_buf = '0;
    logic [0:63] m_out_buf = '0;

    function automatic bit exp_so();
`ifdef CARDINAL_NIC_POLARITY_EN
        return m_out_full && (m_out_buf[0] == net_polarity);
`else
        return m_out_full;
`endif
    endfunction

    function automatic logic [0:63] exp_dout();
        if (!nicEn || nicWrEn) return 64'd0;
        case (addr)
            2'b00: return m_in_buf;
            2'b01: return {63'd0, m_in_full};
            2'b11: return {63'd0, m_out_full};
            default: return 64'd0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        bit take, pop, drain, push;
        if (reset) begin
            m_in_full = 0;
            m_out_full = 0;
            m_in_buf = '0;
            m_out_buf = '0;
        end else begin
            take  = net_si && !m_in_full;
            pop   = nicEn && !nicWrEn && addr == 2'b00 && m_in_full;
            drain = exp_so() && net_ro;
            push  = nicEn && nicWrEn && addr == 2'b10 && !m_out_full;
            if (take) begin
                m_in_buf = net_di;
                m_in_full = 1;
            end else if (pop) begin
                m_in_full = 0;
            end
            if (drain) m_out_full = 0;
            else if (push) begin
                m_out_buf = d_in;
                m_out_full = 1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        check("model_net_ri", {63'd0, net_ri}, {63'd0, !m_in_full});
        check("model_net_so", {63'd0, net_so}, {63'd0, exp_so()});
        check("model_net_do", net_do, m_out_full || reset ? m_out_buf : net_do);
        check("model_d_out", d_out, exp_dout());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic rd_reg(input logic [0:1] a);
        nicEn = 1; nicWrEn = 0; addr = a;
    endtask

    task automatic wr_reg(input logic [0:1] a, input logic [0:63] v);
        nicEn = 1; nicWrEn = 1; addr = a; d_in = v;
    endtask

    task automatic idle();
        nicEn = 0; nicWrEn = 0; addr = 2'b00; d_in = '0;
    endtask

    initial begin
        tick();
        check("rst_ri", {63'd0, net_ri}, 64'd1);
        check("rst_so", {63'd0, net_so}, 64'd0);
        check("rst_do", net_do, 64'd0);
        check("rst_dout", d_out, 64'd0);
        reset = 0;
        tick();

        net_di = 64'hA5A5_0000_0000_0001; net_si = 1;
        tick();
        net_si = 0;
        settle();
        check("arr_ri", {63'd0, net_ri}, 64'd0);
        rd_reg(2'b01);
        settle();
        check("in_stat", d_out, 64'd1);

        rd_reg(2'b00);
        net_di = 64'h0000_0000_0000_1234; net_si = 1;
        settle();
        check("in_read", d_out, 64'hA5A5_0000_0000_0001);
        tick();
        idle();
        settle();
        check("ri_after_read", {63'd0, net_ri}, 64'd1);
        tick();
        net_si = 0;
        settle();
        check("held_accept", {63'd0, net_ri}, 64'd0);
        rd_reg(2'b00);
        settle();
        check("held_data", d_out, 64'h1234);
        tick();
        settle();
        check("stale_read", d_out, 64'h1234);
        check("stale_ri", {63'd0, net_ri}, 64'd1);
        tick();

        wr_reg(2'b10, 64'hFF);
        tick();
        idle();
        settle();
        check("out_so", {63'd0, net_so}, 64'd1);
        rd_reg(2'b11);
        settle();
        check("out_stat", d_out, 64'd1);
        rd_reg(2'b10);
        settle();
        check("out_buf_read", d_out, 64'd0);
        wr_reg(2'b10, 64'h1);
        settle();
        check("wr_dout_zero", d_out, 64'd0);
        tick();
        idle();
        settle();
        check("drop_full", net_do, 64'hFF);

        wr_reg(2'b10, 64'h2); net_ro = 1;
        tick();
        net_ro = 0;
        settle();
        check("drain_only_so", {63'd0, net_so}, 64'd0);
        check("drain_only_do", net_do, 64'hFF);
        tick();
        idle();
        settle();
        check("retry_do", net_do, 64'h2);
        check("retry_so", {63'd0, net_so}, 64'd1);
        net_ro = 1;
        tick();
        net_ro = 0;
        tick();

`ifdef CARDINAL_NIC_POLARITY_EN
        net_polarity = 0;
        wr_reg(2'b10, 64'h8000_0000_0000_0000);
        tick();
        idle();
        net_ro = 1;
        settle();
        check("pol_block", {63'd0, net_so}, 64'd0);
        tick();
        net_polarity = 1;
        settle();
        check("pol_open", {63'd0, net_so}, 64'd1);
        tick();
        net_ro = 0;
        settle();
        check("pol_drained", {63'd0, net_so}, 64'd0);
        net_polarity = 0;
        tick();
`endif

        net_si = 1; net_di = 64'hDEAD_BEEF_0000_0042;
        wr_reg(2'b10, 64'h77);
        tick();
        net_si = 0;
        idle();
        settle();
        check("both_ri", {63'd0, net_ri}, 64'd0);
        check("both_so", {63'd0, net_so}, 64'd1);
        check("both_do", net_do, 64'h77);
        #1;
        reset = 1;
        #1;
        check("async_ri", {63'd0, net_ri}, 64'd1);
        check("async_so", {63'd0, net_so}, 64'd0);
        check("async_do", net_do, 64'd0);
        tick();
        reset = 0;
        rd_reg(2'b00);
        settle();
        check("rst_discard", d_out, 64'd0);
        tick();
        idle();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
